// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flushes and memory-wait stalls,
// plus a saturating count of decode-stall cycles.
module hazard_control_unit #(
    parameter int unsigned ADDR_WIDTH          = 4,
    parameter int unsigned BRANCH_FLUSH_CYCLES = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  ex_is_valid_i,
    input  logic                  ex_mem_read_en_i,
    input  logic [ADDR_WIDTH-1:0] ex_reg_dest_addr_i,
    input  logic                  de_is_valid_i,
    input  logic [ADDR_WIDTH-1:0] de_reg_1_source_addr_i,
    input  logic [ADDR_WIDTH-1:0] de_reg_2_source_addr_i,
    input  logic [ADDR_WIDTH-1:0] de_reg_3_source_addr_i,
    input  logic [2:0]            de_uses_reg_i,
    input  logic                  branch_taken_i,
    input  logic                  mem_busy_i,
    output logic                  stall_fetch_o,
    output logic                  stall_decode_o,
    output logic                  flush_pipeline_o,
    output logic [1:0]            hazard_state_o,
    output logic [15:0]           stall_cycles_o
);

    localparam logic       FLUSH_PIPELINE = 1'b1;
    localparam logic [2:0] FLUSH_LOAD     = 3'(BRANCH_FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle        = 2'd0,
        StLoadStall   = 2'd1,
        StBranchFlush = 2'd2,
        StMemWait     = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic [15:0] stall_cnt_q;
    logic        load_use;
    logic        branch;

    always_comb begin
        load_use = 1'b0;
        if (ex_is_valid_i && ex_mem_read_en_i && de_is_valid_i) begin
            load_use = (de_uses_reg_i[0] && (de_reg_1_source_addr_i == ex_reg_dest_addr_i)) ||
                       (de_uses_reg_i[1] && (de_reg_2_source_addr_i == ex_reg_dest_addr_i)) ||
                       (de_uses_reg_i[2] && (de_reg_3_source_addr_i == ex_reg_dest_addr_i));
        end
    end

    assign branch = branch_taken_i && ex_is_valid_i;

    always_comb begin
        state_d          = state_q;
        flush_cnt_d      = flush_cnt_q;
        stall_fetch_o    = 1'b0;
        stall_decode_o   = 1'b0;
        flush_pipeline_o = ~FLUSH_PIPELINE;
        if (!reset_i) begin
            // Hold the decode/execute register as a bubble while in reset.
            flush_pipeline_o = FLUSH_PIPELINE;
            state_d          = StIdle;
            flush_cnt_d      = 3'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (branch) begin
                        flush_pipeline_o = FLUSH_PIPELINE;
                        flush_cnt_d      = FLUSH_LOAD;
                        state_d          = (FLUSH_LOAD != 3'd0) ? StBranchFlush : StIdle;
                    end else if (mem_busy_i) begin
                        stall_fetch_o  = 1'b1;
                        stall_decode_o = 1'b1;
                        state_d        = StMemWait;
                    end else if (load_use) begin
                        stall_fetch_o    = 1'b1;
                        stall_decode_o   = 1'b1;
                        flush_pipeline_o = FLUSH_PIPELINE;
                        state_d          = StLoadStall;
                    end
                end
                StLoadStall: begin
                    state_d = StIdle;
                end
                StBranchFlush: begin
                    flush_pipeline_o = FLUSH_PIPELINE;
                    flush_cnt_d      = flush_cnt_q - 3'd1;
                    if (flush_cnt_q <= 3'd1) begin
                        flush_cnt_d = 3'd0;
                        state_d     = StIdle;
                    end
                end
                StMemWait: begin
                    stall_fetch_o  = mem_busy_i;
                    stall_decode_o = mem_busy_i;
                    if (!mem_busy_i) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q     <= StIdle;
            flush_cnt_q <= 3'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            if (stall_decode_o && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign hazard_state_o = reset_i ? state_q : StIdle;
    assign stall_cycles_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit with a cycle-level reference model checked every cycle.
module tb_hazard_control_unit;

    localparam int unsigned AW  = 4;
    localparam int unsigned NFL = 2;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          ex_v, ex_ld, de_v, br, mb;
    logic [AW-1:0] ex_rd;
    logic [AW-1:0] src [3];
    logic [2:0]    uses;
    logic          sf, sd, fl;
    logic [1:0]    st;
    logic [15:0]   sc;

    int vectors     = 0;
    int miscompares = 0;
    bit check_en    = 1'b0;

    // Reference model: pending flush cycles, bubble cycle, memory-wait flag, stall count.
    int flush_left = 0;
    bit in_bubble  = 1'b0;
    bit in_mem     = 1'b0;
    int exp_cnt    = 0;
    int c0;

    hazard_control_unit #(
        .ADDR_WIDTH         (AW),
        .BRANCH_FLUSH_CYCLES(NFL)
    ) dut (
        .clk_i                 (clk),
        .reset_i               (reset_i),
        .ex_is_valid_i         (ex_v),
        .ex_mem_read_en_i      (ex_ld),
        .ex_reg_dest_addr_i    (ex_rd),
        .de_is_valid_i         (de_v),
        .de_reg_1_source_addr_i(src[0]),
        .de_reg_2_source_addr_i(src[1]),
        .de_reg_3_source_addr_i(src[2]),
        .de_uses_reg_i         (uses),
        .branch_taken_i        (br),
        .mem_busy_i            (mb),
        .stall_fetch_o         (sf),
        .stall_decode_o        (sd),
        .flush_pipeline_o      (fl),
        .hazard_state_o        (st),
        .stall_cycles_o        (sc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_load_use();
        bit hit = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (uses[k] && src[k] == ex_rd) hit = 1'b1;
        end
        return ex_v && ex_ld && de_v && hit;
    endfunction

    task automatic model_out(output logic e_sf, output logic e_sd, output logic e_fl,
                             output logic [1:0] e_st);
        e_sf = 1'b0; e_sd = 1'b0; e_fl = 1'b0; e_st = 2'd0;
        if (!reset_i) begin
            e_fl = 1'b1;
        end else if (flush_left > 0) begin
            e_fl = 1'b1; e_st = 2'd2;
        end else if (in_bubble) begin
            e_st = 2'd1;
        end else if (in_mem) begin
            e_st = 2'd3; e_sf = mb; e_sd = mb;
        end else if (br && ex_v) begin
            e_fl = 1'b1;
        end else if (mb) begin
            e_sf = 1'b1; e_sd = 1'b1;
        end else if (model_load_use()) begin
            e_sf = 1'b1; e_sd = 1'b1; e_fl = 1'b1;
        end
    endtask

    always @(posedge clk) begin : model_update
        logic a, b, c;
        logic [1:0] d;
        model_out(a, b, c, d);
        if (!reset_i) begin
            flush_left <= 0; in_bubble <= 1'b0; in_mem <= 1'b0; exp_cnt <= 0;
        end else begin
            if (b && exp_cnt < 65535) exp_cnt <= exp_cnt + 1;
            if (flush_left > 0)               flush_left <= flush_left - 1;
            else if (in_bubble)               in_bubble <= 1'b0;
            else if (in_mem)                  in_mem <= mb;
            else if (br && ex_v)              flush_left <= NFL - 1;
            else if (mb)                      in_mem <= 1'b1;
            else if (model_load_use())        in_bubble <= 1'b1;
        end
    end

    always @(negedge clk) begin : compare
        logic a, b, c;
        logic [1:0] d;
        if (check_en) begin
            model_out(a, b, c, d);
            check("stall_fetch", sf, a);
            check("stall_decode", sd, b);
            check("flush", fl, c);
            check("state", st, d);
            check("stall_cycles", sc, exp_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        ex_v = 0; ex_ld = 0; ex_rd = '0; de_v = 0; uses = '0; br = 0; mb = 0;
        for (int k = 0; k < 3; k++) src[k] = '0;
    endtask

    initial begin
        logic [3:0] neg [4];
        reset_i = 1'b0;
        clear();
        tick();
        check_en = 1'b1;
        #1;
        check("rst_sf", sf, 0); check("rst_sd", sd, 0); check("rst_fl", fl, 1);
        check("rst_st", st, 0); check("rst_sc", sc, 0);
        tick();
        reset_i = 1'b1;

        // Load r3 in EX, decode reads r3 through source 2
        ex_v = 1; ex_ld = 1; ex_rd = 3; de_v = 1; src[0] = 1; src[1] = 3; src[2] = 5; uses = 3'b010;
        #1;
        check("lu_c0_sf", sf, 1); check("lu_c0_sd", sd, 1); check("lu_c0_fl", fl, 1);
        check("lu_c0_st", st, 0);
        tick();
        #1;
        check("lu_c1_st", st, 1); check("lu_c1_sd", sd, 0); check("lu_c1_fl", fl, 0);
        tick();
        clear();
        #1;
        check("lu_c2_st", st, 0); check("lu_c2_sc", sc, 1); check("model_cnt1", exp_cnt, 1);

        // Each source position matches on its own; other use bits clear ignore a match
        for (int k = 0; k < 3; k++) begin
            clear();
            ex_v = 1; ex_ld = 1; ex_rd = 7; de_v = 1; src[k] = 7;
            uses = ~(3'b001 << k);
            #1;
            check("lu_masked_sd", sd, 0);
            uses = 3'b001 << k;
            #1;
            check("lu_src_sd", sd, 1);
            tick();
            clear();
            tick();
        end

        // No stall: uses clear, EX invalid, EX not a load, decode invalid
        neg[0] = 4'b1110; neg[1] = 4'b0111; neg[2] = 4'b1011; neg[3] = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            clear();
            ex_rd = 3; src[0] = 3;
            ex_v = neg[i][3]; ex_ld = neg[i][2]; de_v = neg[i][1]; uses = {2'b00, neg[i][0]};
            #1;
            check("neg_sd", sd, 0); check("neg_fl", fl, 0);
            tick();
            check("neg_st", st, 0);
        end

        // Taken branch beats simultaneous mem_busy and load-use
        clear();
        br = 1; ex_v = 1; ex_ld = 1; ex_rd = 3; de_v = 1; src[0] = 3; uses = 3'b001; mb = 1;
        #1;
        check("br_c0_fl", fl, 1); check("br_c0_sd", sd, 0); check("br_c0_st", st, 0);
        tick();
        br = 0;
        #1;
        check("br_c1_fl", fl, 1); check("br_c1_sd", sd, 0); check("br_c1_st", st, 2);
        tick();
        clear();
        #1;
        check("br_c2_fl", fl, 0); check("br_c2_st", st, 0);

        // Branch with invalid EX is not taken; mem_busy wins
        br = 1; mb = 1;
        #1;
        check("brinv_sd", sd, 1); check("brinv_fl", fl, 0);
        tick();
        br = 0; mb = 0;
        #1;
        check("brinv_st", st, 3); check("brinv_sd1", sd, 0);
        tick();
        check("brinv_st2", st, 0);

        // mem_busy for 4 cycles; a branch during the wait is ignored
        clear();
        c0 = exp_cnt;
        mb = 1;
        for (int i = 0; i < 4; i++) begin
            br = (i == 2); ex_v = (i == 2);
            #1;
            check("mw_sd", sd, 1); check("mw_fl", fl, 0);
            check("mw_st", st, (i == 0) ? 0 : 3);
            tick();
        end
        clear();
        #1;
        check("mw_end_sd", sd, 0); check("mw_end_st", st, 3);
        tick();
        check("mw_idle_st", st, 0); check("mw_sc", sc, c0 + 4);

        // Reset during the second cycle of a memory wait
        mb = 1;
        tick();
        tick();
        reset_i = 0;
        #1;
        check("rmw_sd", sd, 0); check("rmw_sf", sf, 0); check("rmw_fl", fl, 1);
        check("rmw_st", st, 0);
        tick();
        reset_i = 1; mb = 0;
        #1;
        check("rmw_post_st", st, 0); check("rmw_post_sd", sd, 0); check("rmw_post_fl", fl, 0);
        check("rmw_post_sc", sc, 0);

        // Reset during a branch flush
        br = 1; ex_v = 1;
        tick();
        clear();
        reset_i = 0;
        #1;
        check("rbf_fl", fl, 1); check("rbf_st", st, 0);
        tick();
        reset_i = 1;
        #1;
        check("rbf_post_fl", fl, 0); check("rbf_post_st", st, 0);

        // Counter saturation
        mb = 1;
        repeat (70000) tick();
        check("sat_sc", sc, 16'hFFFF);
        mb = 0;
        tick();
        tick();
        check("sat_hold_sc", sc, 16'hFFFF); check("model_sat", exp_cnt, 65535);

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
